// File: rtl/ram_bist.sv
// ---------------------------------------------------------------------------
// ram_bist -- march-style built-in self-test controller for a 16 x 8
// synchronous RAM.
//
// A start pulse (accepted only in IDLE) runs four back-to-back phases over
// addresses 0..DEPTH-1:
//   W0 writes P(a), R0 reads and compares against P(a),
//   W1 writes ~P(a), R1 reads and compares against ~P(a).
// Here P(a) = seed_q ^ {a, ~a}. The test then reports pass/fail and a
// saturating mismatch count.
//
// Ports
//   clk        : single clock, all state on posedge
//   rst        : synchronous active-high reset
//   start      : one-cycle test request, sampled only in IDLE
//   seed       : pattern seed, latched on the accepting edge
//   busy       : high from the accepting edge until done
//   done       : one-cycle completion pulse
//   pass       : last completed test saw zero mismatches
//   err_count  : mismatches in the last test (0..2*DEPTH)
//   fail_addr  : address of the first mismatch
//   fail_data  : data read at the first mismatch
//   fail_phase : read phase of the first mismatch (0 = R0, 1 = R1)
//   addr/wr/din: registered RAM port drive
//   dout       : RAM registered read data
//
// Build option: define RAM_BIST_ERR_LOG_EN to keep the first-mismatch
// capture registers. Without it fail_* are tied to 0 and the port list is
// unchanged.
// ---------------------------------------------------------------------------
module ram_bist #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [5:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              fail_phase,
    output logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [5:0]        ERR_MAX   = 6'(2 * DEPTH);

    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, FIN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr;
    logic [DATA_W-1:0]   r_din;
    logic [DATA_W-1:0]   r_seed;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [5:0]          r_err;

    logic [ADDR_W-1:0]   w_addr_next;
    logic                w_wr_next;
    logic [DATA_W-1:0]   w_din_next;
    logic                w_accept;
    logic [DATA_W-1:0]   w_seed_eff;
    logic                w_last;

    // Compare pipeline: holds the read issued on the previous cycle while
    // the RAM produces its data.
    logic                r_cmp_valid;
    logic [DATA_W-1:0]   r_cmp_exp;
    logic                w_mismatch;
    logic [5:0]          w_err_next;

    function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] s,
                                              input logic [ADDR_W-1:0] a);
        return s ^ {a, ~a};
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // ---------------- next-state logic ----------------
    assign w_last   = (r_addr == LAST_ADDR);
    assign w_accept = (r_state == IDLE) && start;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = W0;
            W0:      if (w_last) w_state_next = R0;
            R0:      if (w_last) w_state_next = W1;
            W1:      if (w_last) w_state_next = R1;
            R1:      if (w_last) w_state_next = FIN;
            FIN:                 w_state_next = IDLE;
            default:             w_state_next = IDLE;
        endcase
    end

    // ---------------- output (next-value) logic ----------------
    // The seed input is used directly on the accepting edge, because the
    // W0 address-0 write data is registered on that same edge.
    assign w_seed_eff = w_accept ? seed : r_seed;

    always_comb begin
        w_addr_next = r_addr;
        if (w_accept)
            w_addr_next = '0;
        else if ((r_state == W0) || (r_state == R0) || (r_state == W1) ||
                 ((r_state == R1) && !w_last))
            w_addr_next = r_addr + 1'b1;   // wraps to 0 into the next phase

        w_wr_next = (w_state_next == W0) || (w_state_next == W1);

        w_din_next = r_din;
        if (w_state_next == W0)
            w_din_next = pat(w_seed_eff, w_addr_next);
        else if (w_state_next == W1)
            w_din_next = ~pat(w_seed_eff, w_addr_next);
    end

    // ---------------- compare and error count ----------------
    assign w_mismatch = r_cmp_valid && (dout != r_cmp_exp);

    always_comb begin
        w_err_next = r_err;
        if (w_accept)
            w_err_next = '0;
        else if (w_mismatch && (r_err != ERR_MAX))
            w_err_next = r_err + 6'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_din       <= '0;
            r_seed      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_exp   <= '0;
        end else begin
            r_addr      <= w_addr_next;
            r_wr        <= w_wr_next;
            r_din       <= w_din_next;
            if (w_accept) r_seed <= seed;
            r_busy      <= (w_state_next != IDLE);
            r_done      <= (r_state == FIN);
            r_err       <= w_err_next;
            // pass includes the final R1 compare, which lands on this edge
            if (w_accept)              r_pass <= 1'b0;
            else if (r_state == FIN)   r_pass <= (w_err_next == 6'd0);
            r_cmp_valid <= (r_state == R0) || (r_state == R1);
            r_cmp_exp   <= (r_state == R1) ? ~pat(r_seed, r_addr)
                                           :  pat(r_seed, r_addr);
        end
    end

`ifdef RAM_BIST_ERR_LOG_EN
    logic [ADDR_W-1:0] r_cmp_addr;
    logic              r_cmp_phase;
    logic              r_logged;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;
    logic              r_fail_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_addr   <= '0;
            r_cmp_phase  <= 1'b0;
            r_logged     <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
            r_fail_phase <= 1'b0;
        end else begin
            r_cmp_addr  <= r_addr;
            r_cmp_phase <= (r_state == R1);
            if (w_accept) begin
                r_logged     <= 1'b0;
                r_fail_addr  <= '0;
                r_fail_data  <= '0;
                r_fail_phase <= 1'b0;
            end else if (w_mismatch && !r_logged) begin
                r_logged     <= 1'b1;
                r_fail_addr  <= r_cmp_addr;
                r_fail_data  <= dout;
                r_fail_phase <= r_cmp_phase;
            end
        end
    end

    assign fail_addr  = r_fail_addr;
    assign fail_data  = r_fail_data;
    assign fail_phase = r_fail_phase;
`else
    assign fail_addr  = '0;
    assign fail_data  = '0;
    assign fail_phase = 1'b0;
`endif

    assign addr      = r_addr;
    assign wr        = r_wr;
    assign din       = r_din;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;

endmodule

// File: tb/tb_ram_bist.sv
// ---------------------------------------------------------------------------
// tb_ram_bist -- directed self-checking bench for ram_bist.
// Contains a 16 x 8 RAM model with per-word stuck-at fault injection on the
// read path. Expected values are hand-derived from the march pattern
// P(a) = seed ^ {a, ~a}.
// ---------------------------------------------------------------------------
module tb_ram_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic       busy, done, pass;
    logic [5:0] err_count;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;
    logic       fail_phase;
    logic [3:0] addr;
    logic       wr;
    logic [7:0] din;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    // RAM model and fault controls
    logic [7:0] mem [16];
    logic       f_all  = 1'b0;
    logic [3:0] f_addr = 4'd0;
    logic [7:0] f_and  = 8'hFF;
    logic [7:0] f_or   = 8'h00;

    ram_bist #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_addr(fail_addr), .fail_data(fail_data), .fail_phase(fail_phase),
        .addr(addr), .wr(wr), .din(din), .dout(dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr)
            mem[addr] <= din;
        else
            dout <= (f_all || (addr == f_addr)) ? ((mem[addr] & f_and) | f_or)
                                                : mem[addr];
    end

    function automatic logic [7:0] pat(input logic [7:0] s, input logic [3:0] a);
        return s ^ {a, ~a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_fault(input bit all, input logic [3:0] a,
                             input logic [7:0] am, input logic [7:0] om);
        f_all = all; f_addr = a; f_and = am; f_or = om;
    endtask

    // Called just after a negedge; start is accepted at the next posedge (E0).
    // Ends just after the negedge following E65.
    task automatic run(input string name, input logic [7:0] sd, input bit glitch,
                       input logic [5:0] e_err, input bit e_pass,
                       input logic [3:0] e_fa, input logic [7:0] e_fd, input bit e_fp);
        int bad = 0;
        int nwr = 0;
        int ndone = 0;
        int nbusy_lo = 0;
        logic [3:0] a;
        seed  = sd;
        start = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);                       // just after E_i
            start = glitch && ((i == 9) || (i == 29));
            a = 4'(i % 16);
            if (i == 0) begin
                chk({name, ":busy_rise"}, busy, 1);
                chk({name, ":err_clear"}, err_count, 0);
            end
            if (addr !== a) bad++;
            if (wr) nwr++;
            if (wr !== ((i / 16) == 0 || (i / 16) == 2)) bad++;
            if ((i / 16) == 0 && din !== pat(sd, a)) bad++;
            if ((i / 16) == 2 && din !== ~pat(sd, a)) bad++;
            if (done) ndone++;
            if (!busy) nbusy_lo++;
        end
        chk({name, ":seq"}, bad, 0);
        chk({name, ":wr_cycles"}, nwr, 32);
        chk({name, ":early_done"}, ndone, 0);
        chk({name, ":busy_held"}, nbusy_lo, 0);
        @(negedge clk);                           // after E64 (FIN)
        chk({name, ":fin_wr"}, wr, 0);
        chk({name, ":fin_busy"}, busy, 1);
        chk({name, ":fin_done"}, done, 0);
        chk({name, ":fin_addr"}, addr, 15);
        @(negedge clk);                           // after E65
        chk({name, ":done"}, done, 1);
        chk({name, ":busy_fall"}, busy, 0);
        chk({name, ":pass"}, pass, e_pass);
        chk({name, ":err_count"}, err_count, e_err);
`ifdef RAM_BIST_ERR_LOG_EN
        chk({name, ":fail_addr"}, fail_addr, e_fa);
        chk({name, ":fail_data"}, fail_data, e_fd);
        chk({name, ":fail_phase"}, fail_phase, e_fp);
`else
        chk({name, ":fail_addr"}, fail_addr, 0);
        chk({name, ":fail_data"}, fail_data, 0);
        chk({name, ":fail_phase"}, fail_phase, 0);
        if (e_fa != 4'd0 || e_fd != 8'd0 || e_fp) begin end
`endif
        $display("run %s seed=%02h err_count=%0d pass=%0b fail=%0h/%02h/%0b",
                 name, sd, err_count, pass, fail_addr, fail_data, fail_phase);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; seed = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst:addr", addr, 0);
        chk("rst:wr", wr, 0);
        chk("rst:din", din, 0);
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:pass", pass, 0);
        chk("rst:err", err_count, 0);
        chk("rst:fail", {fail_addr, fail_data, fail_phase}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fault-free, seed 0
        run("clean", 8'h00, 1'b0, 6'd0, 1'b1, 4'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("clean:done_pulse", done, 0);
        chk("clean:pass_held", pass, 1);

        // Word 5 bit 3 stuck-at-0: R0 reads 0x52 instead of 0x5A, R1 matches
        set_fault(1'b0, 4'd5, 8'hF7, 8'h00);
        run("sa0_w5b3", 8'h00, 1'b0, 6'd1, 1'b0, 4'd5, 8'h52, 1'b0);

        // Word 0 all stuck-at-1, seed FF: R0 expects F0, R1 expects 0F
        set_fault(1'b0, 4'd0, 8'hFF, 8'hFF);
        run("sa1_w0", 8'hFF, 1'b0, 6'd2, 1'b0, 4'd0, 8'hFF, 1'b0);

        // Every word reads 0: all 32 compares fail, count reaches its maximum
        set_fault(1'b1, 4'd0, 8'h00, 8'h00);
        run("all_zero", 8'h00, 1'b0, 6'd32, 1'b0, 4'd0, 8'h00, 1'b0);

        // Fault-free with extra start pulses at E10 and E30
        set_fault(1'b0, 4'd0, 8'hFF, 8'h00);
        run("glitch", 8'h3C, 1'b1, 6'd0, 1'b1, 4'd0, 8'h00, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("glitch:no_restart", busy, 0);
        end

        // Reset at E20 during R0
        set_fault(1'b0, 4'd5, 8'hF7, 8'h00);
        seed = 8'h00; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 19) rst = 1'b1;
        end
        @(negedge clk);                           // after E20
        rst = 1'b0;
        chk("midrst:wr", wr, 0);
        chk("midrst:busy", busy, 0);
        chk("midrst:err", err_count, 0);
        chk("midrst:addr", addr, 0);
        chk("midrst:pass", pass, 0);
        begin
            int nd = 0;
            repeat (4) begin
                @(negedge clk);
                if (done || busy) nd++;
            end
            chk("midrst:quiet", nd, 0);
        end
        // start accepted at E25, full faulty run
        run("after_rst", 8'h00, 1'b0, 6'd1, 1'b0, 4'd5, 8'h52, 1'b0);

        // Back-to-back: the next start is accepted at E66 of the previous run
        set_fault(1'b0, 4'd0, 8'hFF, 8'h00);
        run("b2b", 8'hA5, 1'b0, 6'd0, 1'b1, 4'd0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
